// File: rtl/cmem_pkg.sv
// Shared definitions for the ping-pong coefficient memory.
//   NBANK_DEF / DEPTH_DEF / DW_DEF : default geometry
//   cmem_state_t                   : load/swap controller state encoding
package cmem_pkg;

    localparam int unsigned NBANK_DEF = 8;
    localparam int unsigned DEPTH_DEF = 256;
    localparam int unsigned DW_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SWAP = 2'd2
    } cmem_state_t;

endpackage

// File: rtl/cmem_bank.sv
// One coefficient bank: 2*DEPTH x DW storage holding both coefficient sets.
// The set select forms the address MSB on both ports.
//   clk, rst          : clock, synchronous active-high reset (read register only)
//   rd_en/rd_set/rd_addr -> rd_data : registered read, holds while rd_en low
//   wr_en/wr_set/wr_addr/wr_data    : synchronous write
module cmem_bank
    import cmem_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic                     rd_set,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DW-1:0]            rd_data,
    input  logic                     wr_en,
    input  logic                     wr_set,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]            wr_data
);

    logic [DW-1:0] mem [0:2*DEPTH-1];

    // Storage is deliberately not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_set, wr_addr}] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[{rd_set, rd_addr}];
        end
    end

endmodule

// File: rtl/cmem_pingpong.sv
// Ping-pong coefficient memory: NBANK banks, each holding an active and a
// shadow set. Readers always see the active set; a load session streams beats
// into the shadow set from a flat {bank, addr} pointer; a swap exchanges sets.
//   clk, rst                  : clock, synchronous active-high reset
//   rd_en, rd_addr            : per-bank read request (bank i at [i*AW +: AW])
//   rd_data, rd_valid         : per-bank read data, one cycle after rd_en
//   ld_start, ld_base         : start a load session at flat index ld_base
//   ld_valid, ld_data, ld_last, ld_ready : load beat handshake
//   swap_req, swap_ack        : set exchange request / one-cycle completion pulse
//   active_set, busy          : set served to readers / controller not idle
module cmem_pingpong
    import cmem_pkg::*;
#(
    parameter int unsigned NBANK = NBANK_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      rd_en,
    input  logic [NBANK*$clog2(DEPTH)-1:0]            rd_addr,
    output logic [NBANK*DW-1:0]                       rd_data,
    output logic                                      rd_valid,
    input  logic                                      ld_start,
    input  logic [$clog2(NBANK)+$clog2(DEPTH)-1:0]    ld_base,
    input  logic                                      ld_valid,
    input  logic [DW-1:0]                             ld_data,
    input  logic                                      ld_last,
    output logic                                      ld_ready,
    input  logic                                      swap_req,
    output logic                                      swap_ack,
    output logic                                      active_set,
    output logic                                      busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned BW = $clog2(NBANK);
    localparam int unsigned PW = BW + AW;

    cmem_state_t state, state_nxt;
    logic        pending, pending_nxt;
    logic [PW-1:0] ptr;
    logic          ld_accept;

    // rst gates the write so a beat offered during reset never lands.
    assign ld_accept = (state == ST_LOAD) && ld_valid && !rst;
    assign ld_ready  = (state == ST_LOAD);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            ST_IDLE: begin
                if (ld_start) begin
                    state_nxt = ST_LOAD;
                    if (swap_req) begin
                        pending_nxt = 1'b1;
                    end
                end else if (swap_req) begin
                    state_nxt = ST_SWAP;
                end
            end
            ST_LOAD: begin
                if (swap_req) begin
                    pending_nxt = 1'b1;
                end
                // A request arriving on the last beat still counts.
                if (ld_valid && ld_last) begin
                    state_nxt = (pending || swap_req) ? ST_SWAP : ST_IDLE;
                end
            end
            ST_SWAP: begin
                state_nxt   = ST_IDLE;
                pending_nxt = 1'b0;
            end
            default: begin
                state_nxt   = ST_IDLE;
                pending_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pending    <= 1'b0;
            ptr        <= '0;
            active_set <= 1'b0;
            swap_ack   <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            swap_ack <= (state == ST_SWAP);
            rd_valid <= rd_en;
            if (state == ST_SWAP) begin
                active_set <= ~active_set;
            end
            // Natural binary overflow provides the wrap to flat index 0.
            if (state == ST_IDLE && ld_start) begin
                ptr <= ld_base;
            end else if (ld_accept) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NBANK; i++) begin : g_bank
        logic wr_sel;
        assign wr_sel = ld_accept && (ptr[PW-1:AW] == BW'(i));

        cmem_bank #(
            .DEPTH (DEPTH),
            .DW    (DW)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .rd_en   (rd_en),
            .rd_set  (active_set),
            .rd_addr (rd_addr[i*AW +: AW]),
            .rd_data (rd_data[i*DW +: DW]),
            .wr_en   (wr_sel),
            .wr_set  (~active_set),
            .wr_addr (ptr[AW-1:0]),
            .wr_data (ld_data)
        );
    end

endmodule

// File: tb/tb_cmem_pingpong.sv
module tb_cmem_pingpong;
    import cmem_pkg::*;

    localparam int NB  = 8;
    localparam int DEP = 256;
    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int BW  = 3;
    localparam int TOT = NB * DEP;

    typedef logic [NB*DW-1:0] wide_t;
    typedef logic [NB*AW-1:0] addr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_en;
    addr_t             rd_addr;
    wide_t             rd_data;
    logic              rd_valid;
    logic              ld_start;
    logic [BW+AW-1:0]  ld_base;
    logic              ld_valid;
    logic [DW-1:0]     ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              swap_req;
    logic              swap_ack;
    logic              active_set;
    logic              busy;

    always #5 clk = ~clk;

    cmem_pingpong #(
        .NBANK (NB),
        .DEPTH (DEP),
        .DW    (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .ld_start   (ld_start),
        .ld_base    (ld_base),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .active_set (active_set),
        .busy       (busy)
    );

    // Reference model: two flat coefficient sets plus written flags.
    logic [DW-1:0] mm      [2][TOT];
    bit            wr_flag [2][TOT];
    logic          act_m;
    logic [DW-1:0] dq [$];

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input wide_t obs, input wide_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] next_data();
        if (dq.size() != 0) return dq.pop_front();
        return DW'($urandom);
    endfunction

    function automatic addr_t rand_addrs();
        addr_t a;
        for (int b = 0; b < NB; b++) a[b*AW +: AW] = AW'($urandom);
        return a;
    endfunction

    // Expected read data for set s; mask covers only locations with known content.
    task automatic expect_read(input logic s, input addr_t a, output wide_t exp_d, output wide_t mask);
        exp_d = '0;
        mask  = '0;
        for (int b = 0; b < NB; b++) begin
            int flat;
            flat = b * DEP + int'(a[b*AW +: AW]);
            if (wr_flag[s][flat]) begin
                exp_d[b*DW +: DW] = mm[s][flat];
                mask[b*DW +: DW]  = '1;
            end
        end
    endtask

    // Read in IDLE with a stray load beat offered (must be ignored), then check hold.
    task automatic read_check(input addr_t a);
        wide_t exp_d, mask;
        expect_read(act_m, a, exp_d, mask);
        rd_addr  = a;
        rd_en    = 1'b1;
        ld_valid = 1'b1;
        ld_data  = DW'($urandom);
        tick();
        rd_en    = 1'b0;
        ld_valid = 1'b0;
        chkb("rd_valid", rd_valid, 1'b1);
        chkw("rd_data", rd_data & mask, exp_d);
        rd_addr = rand_addrs();
        tick();
        chkb("rd_valid_low", rd_valid, 1'b0);
        chkw("rd_data_hold", rd_data & mask, exp_d);
        chkb("active_set", active_set, act_m);
        chkb("ld_ready_idle", ld_ready, 1'b0);
    endtask

    task automatic swap_task(input bit rd_during, input addr_t a, input bit hold_req);
        wide_t exp_d, mask;
        swap_req = 1'b1;
        tick();
        swap_req = hold_req;
        chkb("swap_busy", busy, 1'b1);
        chkb("swap_active_old", active_set, act_m);
        chkb("swap_ack_early", swap_ack, 1'b0);
        if (rd_during) begin
            rd_en   = 1'b1;
            rd_addr = a;
        end
        expect_read(act_m, a, exp_d, mask);
        tick();
        swap_req = 1'b0;
        rd_en    = 1'b0;
        chkb("swap_ack", swap_ack, 1'b1);
        chkb("swap_active_new", active_set, ~act_m);
        chkb("swap_idle", busy, 1'b0);
        if (rd_during) begin
            chkb("swap_rd_valid", rd_valid, 1'b1);
            chkw("swap_rd_old_set", rd_data & mask, exp_d);
        end
        act_m = ~act_m;
        tick();
        chkb("swap_ack_pulse", swap_ack, 1'b0);
        chkb("swap_active_stable", active_set, act_m);
        chkb("swap_busy_after", busy, 1'b0);
    endtask

    // Load session; abort_at >= 0 asserts rst (with competing inputs) before that beat.
    task automatic load_task(input int base, input int n, input logic [31:0] swmask,
                             input bit start_swap, input int abort_at, input bit gaps);
        int ptr;
        int k;
        bit pend;
        logic [DW-1:0] d;
        ptr  = base % TOT;
        pend = start_swap;
        k    = 0;
        ld_start = 1'b1;
        ld_base  = (BW+AW)'(base);
        swap_req = start_swap;
        tick();
        ld_start = 1'b0;
        swap_req = 1'b0;
        chkb("ld_ready_start", ld_ready, 1'b1);
        chkb("ld_busy", busy, 1'b1);
        while (k < n) begin
            if (k == abort_at) begin
                rst      = 1'b1;
                ld_valid = 1'b1;
                ld_data  = DW'($urandom);
                ld_start = 1'b1;
                swap_req = 1'b1;
                tick();
                rst      = 1'b0;
                ld_valid = 1'b0;
                ld_start = 1'b0;
                swap_req = 1'b0;
                act_m    = 1'b0;
                chkb("abort_ld_ready", ld_ready, 1'b0);
                chkb("abort_busy", busy, 1'b0);
                chkb("abort_active", active_set, 1'b0);
                chkb("abort_swap_ack", swap_ack, 1'b0);
                chkb("abort_rd_valid", rd_valid, 1'b0);
                chkw("abort_rd_data", rd_data, '0);
                tick();
                chkb("abort_stays_idle", busy, 1'b0);
                return;
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
                ld_start = 1'b1;
                ld_base  = (BW+AW)'($urandom);
                tick();
                ld_start = 1'b0;
                chkb("ld_ready_gap", ld_ready, 1'b1);
                continue;
            end
            d        = next_data();
            ld_valid = 1'b1;
            ld_data  = d;
            ld_last  = (k == n - 1);
            swap_req = (k < 32) ? swmask[k] : 1'b0;
            ld_start = 1'($urandom_range(0, 1));
            ld_base  = (BW+AW)'($urandom);
            tick();
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            swap_req = 1'b0;
            ld_start = 1'b0;
            mm[~act_m][ptr]      = d;
            wr_flag[~act_m][ptr] = 1'b1;
            if (k < 32 && swmask[k]) pend = 1'b1;
            ptr = (ptr + 1) % TOT;
            k++;
            chkb("ld_swap_ack_quiet", swap_ack, 1'b0);
            if (k < n) chkb("ld_ready_beat", ld_ready, 1'b1);
        end
        if (pend) begin
            chkb("ld_to_swap_busy", busy, 1'b1);
            chkb("ld_to_swap_ready", ld_ready, 1'b0);
            tick();
            chkb("ld_swap_ack", swap_ack, 1'b1);
            chkb("ld_swap_active", active_set, ~act_m);
            act_m = ~act_m;
            chkb("ld_swap_idle", busy, 1'b0);
            tick();
            chkb("ld_swap_ack_once", swap_ack, 1'b0);
            chkb("ld_swap_active_stable", active_set, act_m);
        end else begin
            chkb("ld_end_idle", busy, 1'b0);
            chkb("ld_end_ready", ld_ready, 1'b0);
            chkb("ld_end_active", active_set, act_m);
        end
    endtask

    initial begin
        addr_t a;
        wide_t dummy_e, dummy_m;
        act_m = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int f = 0; f < TOT; f++) wr_flag[s][f] = 1'b0;

        // Reset with competing inputs active.
        rst = 1'b1; rd_en = 1'b1; rd_addr = '0; ld_start = 1'b1; ld_base = '0;
        ld_valid = 1'b1; ld_data = '0; ld_last = 1'b0; swap_req = 1'b1;
        tick();
        tick();
        rst = 1'b0; rd_en = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; swap_req = 1'b0;
        chkb("rst_rd_valid", rd_valid, 1'b0);
        chkw("rst_rd_data", rd_data, '0);
        chkb("rst_ld_ready", ld_ready, 1'b0);
        chkb("rst_swap_ack", swap_ack, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_active", active_set, 1'b0);

        // First read after reset, all addresses zero.
        read_check('0);

        // Fill both sets so every later read is fully checkable.
        load_task(0, TOT, 32'h0, 1'b0, -1, 1'b0);
        swap_task(1'b0, '0, 1'b0);
        load_task(0, TOT, 32'h0, 1'b0, -1, 1'b0);
        swap_task(1'b0, '0, 1'b0);
        chkb("fill_active", active_set, 1'b0);

        // Load crossing a bank boundary.
        dq.push_back(16'h1111); dq.push_back(16'h2222);
        dq.push_back(16'h3333); dq.push_back(16'h4444);
        load_task(32'h0FE, 4, 32'h0, 1'b0, -1, 1'b1);
        swap_task(1'b0, '0, 1'b0);
        a = '0; a[0 +: AW] = 8'hFE; a[AW +: AW] = 8'h00;
        read_check(a);
        chkw("b0_FE", wide_t'(rd_data[0 +: DW]), wide_t'(16'h1111));
        chkw("b1_00", wide_t'(rd_data[DW +: DW]), wide_t'(16'h3333));
        a = '0; a[0 +: AW] = 8'hFF; a[AW +: AW] = 8'h01;
        read_check(a);
        chkw("b0_FF", wide_t'(rd_data[0 +: DW]), wide_t'(16'h2222));
        chkw("b1_01", wide_t'(rd_data[DW +: DW]), wide_t'(16'h4444));

        // Pointer wrap from the last flat index back to 0.
        dq.push_back(16'hAAAA); dq.push_back(16'hBBBB);
        load_task(32'h7FF, 2, 32'h0, 1'b0, -1, 1'b0);
        swap_task(1'b0, '0, 1'b0);
        a = '0; a[7*AW +: AW] = 8'hFF; a[0 +: AW] = 8'h00;
        read_check(a);
        chkw("b7_FF", wide_t'(rd_data[7*DW +: DW]), wide_t'(16'hAAAA));
        chkw("b0_00_wrap", wide_t'(rd_data[0 +: DW]), wide_t'(16'hBBBB));

        // Three swap requests during a 10-beat load merge into one swap.
        load_task(32'h123, 10, 32'h92, 1'b0, -1, 1'b1);
        read_check(rand_addrs());

        // ld_start and swap_req together: load first, swap pending.
        load_task(32'h300, 5, 32'h0, 1'b1, -1, 1'b1);
        read_check(rand_addrs());

        // Read in the toggle cycle sees the old set, next read sees the new one.
        a = rand_addrs();
        swap_task(1'b1, a, 1'b1);
        read_check(a);

        // Reset after 3 of 6 beats.
        if (act_m) swap_task(1'b0, '0, 1'b0);
        load_task(32'h5F0, 6, 32'h0, 1'b0, 3, 1'b0);
        swap_task(1'b0, '0, 1'b0);
        a = '0; for (int b = 0; b < NB; b++) a[b*AW +: AW] = AW'(8'hF0 + b % 6);
        a[5*AW +: AW] = 8'hF0;
        read_check(a);
        expect_read(act_m, a, dummy_e, dummy_m);

        // Randomized mix of operations.
        for (int it = 0; it < 40; it++) begin
            int op, n;
            logic [31:0] m;
            op = $urandom_range(0, 4);
            n  = $urandom_range(1, 20);
            m  = $urandom & ((32'd1 << n) - 1);
            case (op)
                0: load_task($urandom_range(0, TOT - 1), n, m, 1'($urandom_range(0, 1)), -1, 1'b1);
                1: swap_task(1'($urandom_range(0, 1)), rand_addrs(), 1'($urandom_range(0, 1)));
                2: load_task($urandom_range(0, TOT - 1), n, 32'h0, 1'b0, $urandom_range(0, n - 1), 1'b1);
                default: read_check(rand_addrs());
            endcase
        end
        read_check(rand_addrs());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cmem_pingpong.md
CMEM_PINGPONG -- requirements
Module: cmem_pingpong

Interface
REQ-001 SHALL have parameter NBANK, default 8: number of coefficient banks and read ports (power of 2).
REQ-002 SHALL have parameter DEPTH, default 256: words per bank per set (power of 2).
REQ-003 SHALL have parameter DW, default 16: coefficient width; AW = clog2(DEPTH), BW = clog2(NBANK).
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port rd_en, input, 1: read strobe applied to all banks.
REQ-007 SHALL have port rd_addr, input, NBANK*AW: per-bank read address, bank i at bits [i*AW +: AW].
REQ-008 SHALL have port rd_data, output, NBANK*DW: per-bank read data, same packing.
REQ-009 SHALL have port rd_valid, output, 1: rd_data valid.
REQ-010 SHALL have port ld_start, input, 1: begin load session.
REQ-011 SHALL have port ld_base, input, BW+AW: start flat index, {bank, addr}.
REQ-012 SHALL have port ld_valid, input, 1: load beat offered.
REQ-013 SHALL have port ld_data, input, DW: load beat data.
REQ-014 SHALL have port ld_last, input, 1: final beat of session.
REQ-015 SHALL have port ld_ready, output, 1: beat accepted when ld_valid & ld_ready.
REQ-016 SHALL have port swap_req, input, 1: request exchange of active/shadow sets.
REQ-017 SHALL have port swap_ack, output, 1: one-cycle pulse, swap done.
REQ-018 SHALL have port active_set, output, 1: set currently served to readers.
REQ-019 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-020 SHALL hold two coefficient sets per bank; reads use active_set, loads write only set ~active_set.
REQ-021 SHALL return rd_data and assert rd_valid exactly one cycle after rd_en; rd_data and rd_valid SHALL hold their values while rd_en is low, with rd_valid low.
REQ-022 SHALL serve a read issued in the same cycle that active_set toggles from the old set.
REQ-023 SHALL implement FSM states IDLE, LOAD, SWAP.
REQ-024 SHALL in IDLE with ld_start capture ld_base into the load pointer and enter LOAD.
REQ-025 SHALL assert ld_ready only in LOAD; each accepted beat writes shadow bank ptr[BW+AW-1:AW], address ptr[AW-1:0], then increments ptr.
REQ-026 SHALL wrap ptr from NBANK*DEPTH-1 to 0 with no error and no stall.
REQ-027 SHALL on an accepted beat with ld_last leave LOAD: enter SWAP if a swap is pending, else IDLE.
REQ-028 SHALL ignore ld_start outside IDLE and ld_valid outside LOAD.
REQ-029 SHALL in IDLE with swap_req and no ld_start enter SWAP.
REQ-030 SHALL when ld_start and swap_req are both asserted in IDLE give the load priority and mark the swap pending.
REQ-031 SHALL record a swap_req seen in LOAD as pending; multiple requests SHALL merge into one swap.
REQ-032 SHALL spend exactly one cycle in SWAP, toggle active_set on exit, pulse swap_ack in the cycle after exit, clear pending, and return to IDLE.
REQ-033 SHALL ignore swap_req while in SWAP.

Reset
REQ-034 SHALL on rst force state IDLE, active_set=0, rd_valid=0, rd_data=0, ld_ready=0, swap_ack=0, busy=0, pending=0, ptr=0.
REQ-035 SHALL leave memory contents unreset; rst mid-LOAD SHALL abandon the session, keeping beats already written.
REQ-036 SHALL give rst priority over every other input in the same cycle.

Structure
REQ-037 SHALL place NBANK, DEPTH, DW defaults and the FSM state encoding in shared package cmem_pkg.
REQ-038 SHALL instantiate NBANK copies of sub-module cmem_bank: a 2*DEPTH x DW memory with one synchronous read port and one write port, set select as the address MSB.

Verification
REQ-039 SHALL cover: rst, then rd_en with all rd_addr=0 -> rd_valid=1 next cycle, active_set=0, busy=0.
REQ-040 SHALL cover: ld_base=0x0FE, 4 beats 0x1111..0x4444 with ld_last on the 4th, then swap -> bank0[0xFE]=0x1111, bank0[0xFF]=0x2222, bank1[0]=0x3333, bank1[1]=0x4444.
REQ-041 SHALL cover: ld_base=0x7FF (NBANK=8, DEPTH=256), 2 beats -> bank7[0xFF] written, then ptr wraps to bank0[0].
REQ-042 SHALL cover: swap_req three times during a 10-beat load -> exactly one swap_ack, active_set toggles once after the last beat.
REQ-043 SHALL cover: rd_en asserted in the cycle active_set toggles -> data returned from the old set; the next read returns the new set.
REQ-044 SHALL cover: rst asserted after 3 of 6 beats -> ld_ready=0, state IDLE, 3 words written to the shadow set, active_set unchanged.
